// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter merging pipeline results with FIFO-buffered load returns.
// Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO straight into the output register.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1_index,
  input  logic [4:0]      rs2_index,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_en,
  output logic [4:0]      rd_index,
  output logic [XLEN-1:0] wb_data,
  output logic            err_waw
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [4:0]      rd_mem   [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [31:0]     sb, sb_nxt;
  logic            pipe_wr, acc, byp, enq, deq, ld_wr;
  logic [4:0]      ld_wr_rd;
  logic [XLEN-1:0] ld_wr_data;

  assign ld_ready = count != FULL;
  assign pipe_wr  = pipe_valid && pipe_rd != 5'd0;
  assign acc      = ld_valid && ld_ready && ld_rd != 5'd0;
`ifdef WB_LOAD_BYPASS_EN
  assign byp = acc && count == '0 && !pipe_wr;
`else
  assign byp = 1'b0;
`endif
  assign enq        = acc && !byp;
  assign deq        = !pipe_wr && count != '0;
  assign ld_wr      = deq || byp;
  assign ld_wr_rd   = byp ? ld_rd : rd_mem[rptr];
  assign ld_wr_data = byp ? ld_data : data_mem[rptr];
  assign rs1_busy   = sb[rs1_index];
  assign rs2_busy   = sb[rs2_index];

  // A new issue to the same rd must survive the clear of the older load.
  always_comb begin
    sb_nxt = sb;
    if (ld_wr && !pipe_wr) sb_nxt[ld_wr_rd] = 1'b0;
    if (issue_valid) sb_nxt[issue_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wptr] <= ld_data;
      rd_mem[wptr]   <= ld_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      sb       <= '0;
      err_waw  <= 1'b0;
      wb_en    <= 1'b0;
      rd_index <= 5'd0;
      wb_data  <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
      sb    <= sb_nxt;
      if ((pipe_valid && sb[pipe_rd]) || (issue_valid && sb[issue_rd])) err_waw <= 1'b1;
      if (pipe_wr) begin
        wb_en    <= 1'b1;
        rd_index <= pipe_rd;
        wb_data  <= pipe_data;
      end else if (ld_wr) begin
        wb_en    <= 1'b1;
        rd_index <= ld_wr_rd;
        wb_data  <= ld_wr_data;
      end else begin
        wb_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  logic        clk = 1'b0, rst = 1'b0;
  logic        pipe_valid = 0, ld_valid = 0, issue_valid = 0;
  logic [4:0]  pipe_rd = 0, ld_rd = 0, issue_rd = 0, rs1_index = 0, rs2_index = 0;
  logic [31:0] pipe_data = 0, ld_data = 0;
  logic        ld_ready, rs1_busy, rs2_busy, wb_en, err_waw;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
  int total = 0, bad = 0;

  wb_arbiter #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_en"}, 32'(wb_en), 32'(en));
    chk({tag, "_rd"}, 32'(rd_index), 32'(rd));
    chk({tag, "_data"}, wb_data, d);
  endtask

  initial begin
    #1;
    chk_wb("rst_hold", 0, 0, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_ready", 32'(ld_ready), 1);
    chk("rst_busy", 32'(rs1_busy), 0);
    // pipeline only
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    tick();
    chk_wb("pipe", 1, 5, 32'hDEADBEEF);
    pipe_rd = 0; pipe_data = 32'h55;
    tick();
    chk_wb("pipe_x0", 0, 5, 32'hDEADBEEF);
    pipe_valid = 0;
    // collision: load return and pipeline result in the same cycle
    issue_valid = 1; issue_rd = 7; rs1_index = 7;
    tick();
    issue_valid = 0;
    chk("col_busy_set", 32'(rs1_busy), 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h33;
    tick();
    ld_valid = 0; pipe_valid = 0;
    chk_wb("col_pipe", 1, 3, 32'h33);
    chk("col_busy_hold", 32'(rs1_busy), 1);
    tick();
    chk_wb("col_load", 1, 7, 32'h1234);
    chk("col_busy_drop", 32'(rs1_busy), 0);
    tick();
    chk("col_idle", 32'(wb_en), 0);
    // fill under continuous pipeline writes
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(8 + i); ld_data = 32'h100 + i;
      chk("fill_ready", 32'(ld_ready), 1);
      tick();
    end
    ld_rd = 20; ld_data = 32'hBAD;
    chk("fill_full", 32'(ld_ready), 0);
    chk_wb("fill_pipe", 1, 1, 32'h11);
    tick();
    ld_valid = 0;
    chk("fill_still_full", 32'(ld_ready), 0);
    pipe_valid = 0;
    tick();
    chk_wb("drain0", 1, 8, 32'h100);
    chk("drain_ready", 32'(ld_ready), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_wb("drain", 1, 5'(8 + i), 32'h100 + i);
    end
    tick();
    chk("drain_done", 32'(wb_en), 0);
    // bypass vs FIFO path on an idle FIFO
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    tick();
    ld_valid = 0;
`ifdef WB_LOAD_BYPASS_EN
    chk_wb("byp_n1", 1, 9, 32'h99);
    tick();
    chk("byp_n2", 32'(wb_en), 0);
`else
    chk("byp_n1", 32'(wb_en), 0);
    tick();
    chk_wb("byp_n2", 1, 9, 32'h99);
`endif
    // x0 load is discarded
    ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
    tick();
    ld_valid = 0;
    tick();
    chk("ld_x0", 32'(wb_en), 0);
    // WAW on a busy register
    issue_valid = 1; issue_rd = 4; rs2_index = 4;
    tick();
    chk("waw_first", 32'(err_waw), 0);
    chk("waw_busy", 32'(rs2_busy), 1);
    tick();
    issue_valid = 0;
    chk("waw_set", 32'(err_waw), 1);
    tick(); tick();
    chk("waw_sticky", 32'(err_waw), 1);
    // reset with three entries queued
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h11;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_rd = 5'(12 + i); ld_data = 32'h200 + i;
      tick();
    end
    ld_valid = 0; pipe_valid = 0;
    #2 rst = 1'b0;
    #1;
    chk_wb("mrst", 0, 0, 0);
    chk("mrst_ready", 32'(ld_ready), 1);
    chk("mrst_busy", 32'(rs2_busy), 0);
    chk("mrst_waw", 32'(err_waw), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_ready_after", 32'(ld_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_no_wb", 32'(wb_en), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the single write port of the integer register file. It merges single-cycle pipeline results with variable-latency load returns from the data cache through a small load-return FIFO. It also keeps a pending-load scoreboard so decode can stall on registers still owed a load value. It sits between the MEM/WB pipeline register, the D-cache response port and the register file.

## Interface
- `XLEN`, 32: data width.
- `DEPTH`, 4: load-return FIFO entries; power of two, ≥2.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pipe_valid` in 1: pipeline result present this cycle. Cannot be back-pressured.
- `pipe_rd` in 5: pipeline destination register.
- `pipe_data` in XLEN: pipeline result.
- `ld_valid` in 1: cache load return present.
- `ld_ready` out 1: FIFO can accept a return. A transfer occurs when `ld_valid && ld_ready`.
- `ld_rd` in 5: load destination register.
- `ld_data` in XLEN: load data.
- `issue_valid` in 1: a load is issued to the cache this cycle.
- `issue_rd` in 5: destination register of the issued load.
- `rs1_index`, `rs2_index` in 5: decode source registers to query.
- `rs1_busy`, `rs2_busy` out 1: the queried register has a pending load.
- `wb_en` out 1: register file write enable.
- `rd_index` out 5: register file write index.
- `wb_data` out XLEN: register file write data.
- `err_waw` out 1: sticky flag. Set when `pipe_valid` or `issue_valid` targets a register whose scoreboard bit is set.

## Operation
- **Output register:** `wb_en`, `rd_index` and `wb_data` are registered. Exactly one source is written per cycle.
- **Priority:** the pipeline always wins. If `pipe_valid` is high and `pipe_rd != 0`, the output register loads the pipeline result.
- **FIFO drain:** if no pipeline write occurs and the FIFO is non-empty, the FIFO head is dequeued into the output register.
- **Idle:** if neither source writes, `wb_en` is 0 and `rd_index`/`wb_data` hold their previous values.
- **x0 handling:**
  - A pipeline result with rd 0 produces no write. It does not block a FIFO drain that cycle.
  - An accepted load with rd 0 is discarded and never enqueued.
- **FIFO:**
  - Circular buffer with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count runs 0..DEPTH.
  - `ld_ready = (count != DEPTH)`, computed from the registered count only. A full FIFO refuses a return even in a cycle where it dequeues.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
- **Scoreboard** (32 bits, bit 0 tied to 0):
  - Set on `issue_valid && issue_rd != 0`.
  - Cleared on the edge where the output register loads a load return for that rd.
  - If set and clear hit the same rd in the same edge, set wins.
  - `rsN_busy = sb[rsN_index]`, a purely combinational read of the scoreboard register.
- **WAW rule:** issue logic must not target a busy register. A violation sets `err_waw`, which is cleared only by reset. Writes still proceed as normal.
- **Reset (mid-operation included):**
  - FIFO emptied, pointers and count 0.
  - Scoreboard 0, `err_waw` 0.
  - `wb_en` 0, `rd_index` 0, `wb_data` 0.
  - `ld_ready` 1 from the first cycle after reset deasserts.
  - In-flight loads are lost.

## Timing
- **Pipeline result** presented in cycle N: `wb_en` high in N+1.
- **Load accepted in cycle N, FIFO path:** enqueued at the end of N. The earliest write is N+2, when N+1 has no pipeline write.
- **Stall per pipeline write:** each cycle with a pipeline write delays the FIFO head by one cycle.
- **Scoreboard bit:** `busy` drops in the same cycle that `wb_en` for that load is high.
- **Throughput:** one writeback per cycle sustained. Under continuous pipeline writes the FIFO fills after DEPTH accepted loads, and `ld_ready` falls the cycle after the DEPTH-th accept.

## Configuration
- **`WB_LOAD_BYPASS_EN` defined:** a load accepted in cycle N, with the FIFO empty and no pipeline write in N, loads the output register directly. `wb_en` is high in N+1, and nothing is enqueued.
- **Not defined:** every non-x0 load goes through the FIFO, with minimum latency N+2. All other behaviour is identical.

## Test plan
- **Reset:** pulse `rst` low while FIFO holds 3 entries. Required: `wb_en`=0, `rd_index`=0, `wb_data`=0, `ld_ready`=1, all busy=0, no write of the flushed entries afterwards.
- **Pipeline only:** `pipe_valid` rd=5 data=0xDEADBEEF in cycle N. Required: `wb_en`=1, `rd_index`=5, `wb_data`=0xDEADBEEF in N+1; rd=0 input gives `wb_en`=0.
- **Collision:**
  - Stimulus: issue load rd=7 (`rs1_index`=7 shows `rs1_busy`=1). Then in cycle N drive `ld_valid` rd=7 data=0x1234 together with `pipe_valid` rd=3.
  - Required: rd 3 written in N+1. rd 7 written with 0x1234 in N+2, and `rs1_busy` falls in N+2.
- **Fill:**
  - Stimulus: hold `pipe_valid` rd=1 continuously and accept 4 loads, rd 8..11, with DEPTH=4.
  - Required: `ld_ready`=0 while full. After pipe stops, rd 8, 9, 10, 11 are written in order on consecutive cycles, and `ld_ready` returns to 1 the cycle after the first drain.
- **Bypass:** idle FIFO, `ld_valid` rd=9 in N. Required: write in N+1 with `WB_LOAD_BYPASS_EN`, N+2 without.
- **WAW:** issue rd=4 twice without a return. Required: `err_waw`=1 from the cycle after the second issue, held until reset.
